nexys_starship_rng_bank: RTL and testbench



---
 rtl/nexys_starship_rng_bank.sv | 96 +++++++++
 tb/tb_nexys_starship_rng_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_rng_bank.sv
// Multi-channel pseudo-random event bank: one Galois LFSR per channel, a
// runtime threshold per channel, and a post-event cooldown; also drives a random hex digit.
module nexys_starship_rng_bank #(
    parameter int              NUM_CH   = 4,
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
    parameter logic [WIDTH-1:0] SEED    = 16'h0001,
    parameter logic [WIDTH-1:0] MIX     = 16'h9E37,
    parameter int              COOLDOWN = 15
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Tick,
    input  logic                  Enable,
    input  logic                  Seed_load,
    input  logic [WIDTH-1:0]      Seed_in,
    input  logic [NUM_CH*8-1:0]   Thresh,
    output logic [NUM_CH-1:0]     Event,
    output logic [3:0]            Rand_hex
);

    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("nexys_starship_rng_bank: WIDTH must be in 8..32");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("nexys_starship_rng_bank: NUM_CH must be in 1..16");
    end

    // Per-channel decorrelated seed; all-zero would lock the LFSR, so it becomes 1.
    function automatic logic [WIDTH-1:0] eff_seed(input logic [WIDTH-1:0] s,
                                                  input int unsigned      ch);
        logic [WIDTH-1:0] e;
        e = s ^ (MIX * WIDTH'(ch));
        if (e == '0) e = WIDTH'(1);
        return e;
    endfunction

    logic [NUM_CH-1:0][WIDTH-1:0] lfsr_q, lfsr_d;
    logic [NUM_CH-1:0][CD_W-1:0]  cd_q, cd_d;
    logic [NUM_CH-1:0]            event_q, event_d;
    logic [3:0]                   hex_q, hex_d;
    logic [NUM_CH-1:0]            fire;

    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fire[i] = Enable && (cd_q[i] == '0) && (lfsr_q[i][7:0] < Thresh[8*i +: 8]);
        end
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        cd_d    = cd_q;
        event_d = '0;
        hex_d   = hex_q;
        if (Seed_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                lfsr_d[i] = eff_seed(Seed_in, i);
                cd_d[i]   = '0;
            end
        end else if (Tick) begin
            hex_d = lfsr_q[0][WIDTH-1 -: 4];
            for (int i = 0; i < NUM_CH; i++) begin
                lfsr_d[i]  = lfsr_q[i][0] ? ((lfsr_q[i] >> 1) ^ TAPS) : (lfsr_q[i] >> 1);
                event_d[i] = fire[i];
                if (fire[i]) begin
                    cd_d[i] = CD_W'(COOLDOWN);
                end else if (cd_q[i] != '0) begin
                    cd_d[i] = cd_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                lfsr_q[i] <= eff_seed(SEED, i);
            end
            cd_q    <= '0;
            event_q <= '0;
            hex_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            cd_q    <= cd_d;
            event_q <= event_d;
            hex_q   <= hex_d;
        end
    end

    assign Event    = event_q;
    assign Rand_hex = hex_q;

endmodule

// File: tb/tb_nexys_starship_rng_bank.sv
// Directed bench for nexys_starship_rng_bank: default 4x16 instance plus an
// 8-bit instance used for the full-period check.
module tb_nexys_starship_rng_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Tick = 1'b0;
    logic        Enable = 1'b0;
    logic        Seed_load = 1'b0;
    logic [15:0] Seed_in = '0;
    logic [31:0] Thresh = '0;
    logic [3:0]  Event;
    logic [3:0]  Rand_hex;

    logic        p_tick = 1'b0;
    logic [1:0]  p_event;
    logic [3:0]  p_hex;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    nexys_starship_rng_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .Enable(Enable),
        .Seed_load(Seed_load), .Seed_in(Seed_in), .Thresh(Thresh),
        .Event(Event), .Rand_hex(Rand_hex)
    );

    nexys_starship_rng_bank #(
        .NUM_CH(2), .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .MIX(8'h37), .COOLDOWN(3)
    ) dut_p (
        .Clk(Clk), .Reset_n(Reset_n), .Tick(p_tick), .Enable(1'b0),
        .Seed_load(1'b0), .Seed_in(8'h00), .Thresh(16'hFFFF),
        .Event(p_event), .Rand_hex(p_hex)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the tick processed.
    task automatic do_tick;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic do_reset;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    logic [3:0] exp_ev;
    logic [3:0] hex_hold;
    int         first_k;
    int         p_events;

    initial begin
        do_reset();
        chk("rst_event", 32'(Event), 32'h0);
        chk("rst_hex",   32'(Rand_hex), 32'h0);
        chk("rst_lfsr0", 32'(dut.lfsr_q[0]), 32'h0001);
        chk("rst_lfsr1", 32'(dut.lfsr_q[1]), 32'h9E36);
        chk("rst_p_lfsr0", 32'(dut_p.lfsr_q[0]), 32'h01);

        // LFSR sequence with all thresholds zero
        Enable = 1'b1;
        Thresh = '0;
        do_tick();
        chk("seq1_lfsr0", 32'(dut.lfsr_q[0]), 32'hB400);
        chk("seq1_hex",   32'(Rand_hex), 32'h0);
        do_tick();
        chk("seq2_lfsr0", 32'(dut.lfsr_q[0]), 32'h5A00);
        chk("seq2_hex",   32'(Rand_hex), 32'hB);
        do_tick();
        chk("seq3_lfsr0", 32'(dut.lfsr_q[0]), 32'h2D00);
        chk("seq3_hex",   32'(Rand_hex), 32'h5);
        chk("seq_event",  32'(Event), 32'h0);

        // Strict threshold: ch0 byte 0x01, ch1 byte 0x36 equal to thresholds
        do_reset();
        Thresh = 32'h0000_3601;
        do_tick();
        chk("thr_equal_nofire", 32'(Event), 32'h0);
        // next bytes: ch0 0x00 < 0x01, ch1 0x1B < 0x1C
        Thresh = 32'h0000_1C01;
        do_tick();
        chk("thr_below_fire", 32'(Event), 32'h3);

        // Fire timing and cooldown on channel 0
        do_reset();
        Thresh = 32'h0000_00FF;
        for (int k = 1; k <= 17; k++) begin
            do_tick();
            exp_ev = (k == 1 || k == 17) ? 4'b0001 : 4'b0000;
            chk($sformatf("cd_tick%0d", k), 32'(Event), 32'(exp_ev));
            @(negedge Clk);
            chk($sformatf("cd_pulse_end%0d", k), 32'(Event), 32'h0);
            repeat (2) @(negedge Clk);
        end
        hex_hold = Rand_hex;
        chk("cd_hex_tick17", 32'(Rand_hex), 32'h7);

        // Reseed with zero seed and a simultaneous tick
        Seed_in   = 16'h0000;
        Seed_load = 1'b1;
        Tick      = 1'b1;
        @(negedge Clk);
        Seed_load = 1'b0;
        Tick      = 1'b0;
        chk("rs_lfsr0", 32'(dut.lfsr_q[0]), 32'h0001);
        chk("rs_lfsr1", 32'(dut.lfsr_q[1]), 32'h9E37);
        chk("rs_cd0",   32'(dut.cd_q[0]), 32'h0);
        chk("rs_event", 32'(Event), 32'h0);
        chk("rs_hex_hold", 32'(Rand_hex), 32'(hex_hold));
        do_tick();
        chk("rs_fire_after", 32'(Event), 32'h1);
        chk("rs_hex_after",  32'(Rand_hex), 32'h0);

        // Asynchronous reset while Event is high and cooldown active
        #2 Reset_n = 1'b0;
        #1;
        chk("ar_event", 32'(Event), 32'h0);
        chk("ar_cd0",   32'(dut.cd_q[0]), 32'h0);
        chk("ar_lfsr0", 32'(dut.lfsr_q[0]), 32'h0001);
        chk("ar_lfsr1", 32'(dut.lfsr_q[1]), 32'h9E36);
        chk("ar_hex",   32'(Rand_hex), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Thresh  = '0;
        @(negedge Clk);
        do_tick();
        chk("ar_tick_lfsr0", 32'(dut.lfsr_q[0]), 32'hB400);
        chk("ar_tick_event", 32'(Event), 32'h0);

        // Full period of the 8-bit instance with back-to-back ticks, Enable low
        first_k  = 0;
        p_events = 0;
        p_tick   = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge Clk);
            if (dut_p.lfsr_q[0] == 8'h01 && first_k == 0) first_k = k;
            if (p_event != 2'b00) p_events++;
        end
        p_tick = 1'b0;
        chk("period_len", 32'(first_k), 32'd255);
        chk("period_no_event", 32'(p_events), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
